// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared encodings for the multicycle MIPS control FSM:
//   - instruction opcodes and R-type funct codes recognised by the controller
//   - ALU control codes driven to the datapath ALU
//   - alu_op codes between the main FSM and the ALU decoder
//   - datapath mux-select encodings (pc_src, alu_src_a/b, reg_dst, mem_to_reg)
//   - the 4-bit FSM state enumeration
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Main FSM -> ALU decoder operation class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REGA   = 2'b11;

    // ALU operand selects
    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REGA    = 1'b1;
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // Register-file write destination and write-data source
    localparam logic [1:0] REGDST_RT     = 2'b00;
    localparam logic [1:0] REGDST_RD     = 2'b01;
    localparam logic [1:0] REGDST_RA     = 2'b10;
    localparam logic [1:0] M2R_ALUOUT    = 2'b00;
    localparam logic [1:0] M2R_MDR       = 2'b01;
    localparam logic [1:0] M2R_PC        = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_JR     = 4'd13
    } state_e;

endpackage

// File: rtl/mc_aludec.sv
// ---------------------------------------------------------------------------
// mc_aludec
// ALU control decoder. Maps the operation class from the main FSM plus the
// R-type funct field onto an ALU control code, and reports whether the funct
// is one the controller supports and whether it is jr.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct
//   funct       in  6  IR[5:0]
//   alu_ctrl    out 4  ALU control code
//   funct_legal out 1  funct is a supported R-type function (incl. jr)
//   is_jr       out 1  funct is jr
// ---------------------------------------------------------------------------
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       funct_legal,
    output logic       is_jr
);

    logic [3:0] funct_ctrl;

    always_comb begin
        funct_ctrl  = ALU_ADD;
        funct_legal = 1'b1;
        is_jr       = 1'b0;
        case (funct)
            F_ADD:   funct_ctrl = ALU_ADD;
            F_SUB:   funct_ctrl = ALU_SUB;
            F_AND:   funct_ctrl = ALU_AND;
            F_OR:    funct_ctrl = ALU_OR;
            F_SLT:   funct_ctrl = ALU_SLT;
            F_JR:    is_jr      = 1'b1;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            default:   alu_ctrl = funct_ctrl;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
// Multicycle control FSM for the MIPS core. Steps the shared PC/IR/ALU/
// regfile/unified-memory datapath through one instruction at a time and
// drives per-state enables and mux selects. Fetch and data accesses wait on
// mem_ready so slow memory simply stretches those states.
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   opcode, funct       IR[31:26], IR[5:0]
//   zero                ALU zero flag (used in BRANCH)
//   mem_ready           memory access completes this cycle
//   mem_re, mem_we      memory read / write request
//   iord                memory address select (0 PC, 1 ALUOut)
//   ir_we, pc_we        IR / PC load enables
//   pc_src              PC source select
//   alu_src_a/b, alu_ctrl  ALU operand selects and operation
//   reg_dst, mem_to_reg, we_reg  register file write controls
//   instr_done          pulse in the final state of each retired instruction
//   illegal_op          pulse when DECODE sees an unsupported instruction
// All outputs are held at 0 while rst_n is low.
// ---------------------------------------------------------------------------
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_re,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_ctrl,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       we_reg,
    output logic       instr_done,
    output logic       illegal_op
);

    state_e     state_q;
    state_e     state_d;
    logic       decode_illegal;
    logic [1:0] alu_op;
    logic [3:0] alu_ctrl_dec;
    logic       funct_legal;
    logic       is_jr;

    // funct_legal / is_jr do not depend on alu_op, so one decoder serves
    // both the EXEC/BRANCH ALU control and the DECODE legality check.
    mc_aludec u_aludec (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_ctrl    (alu_ctrl_dec),
        .funct_legal (funct_legal),
        .is_jr       (is_jr)
    );

    assign alu_op = (state_q == S_EXEC)   ? ALUOP_FUNCT :
                    (state_q == S_BRANCH) ? ALUOP_SUB   : ALUOP_ADD;

    assign alu_ctrl = rst_n ? alu_ctrl_dec : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        decode_illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        if (!funct_legal) begin
                            state_d        = S_FETCH;
                            decode_illegal = 1'b1;
                        end else if (is_jr) begin
                            state_d = S_JR;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
                    OP_JAL:  state_d = S_JAL;
                    default: begin
                        state_d        = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            // IR holds the same instruction, so opcode still separates lw/sw.
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; everything stays 0 while reset is asserted so an
    // aborted instruction cannot produce any further write.
    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        we_reg     = 1'b0;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_re    = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_we = 1'b1;
                        pc_we = 1'b1;
                    end
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH2;
                    illegal_op = decode_illegal;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = SRCA_REGA;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                end
                S_MEMWB: begin
                    we_reg     = 1'b1;
                    reg_dst    = REGDST_RT;
                    mem_to_reg = M2R_MDR;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    mem_we     = 1'b1;
                    iord       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a = SRCA_REGA;
                    alu_src_b = SRCB_REGB;
                end
                S_ALUWB: begin
                    we_reg     = 1'b1;
                    reg_dst    = REGDST_RD;
                    mem_to_reg = M2R_ALUOUT;
                    instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    we_reg     = 1'b1;
                    reg_dst    = REGDST_RT;
                    mem_to_reg = M2R_ALUOUT;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_REGA;
                    alu_src_b  = SRCB_REGB;
                    pc_src     = PCSRC_ALUOUT;
                    pc_we      = zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_src     = PCSRC_JUMP;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    pc_src     = PCSRC_JUMP;
                    pc_we      = 1'b1;
                    we_reg     = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = M2R_PC;
                    instr_done = 1'b1;
                end
                S_JR: begin
                    pc_src     = PCSRC_REGA;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
